// File: rtl/ldm_stm_seq_pkg.sv
// Shared types and constants for the load/store-multiple sequencer.
// Holds the sequencer state encoding and a register-list population count.
package ldm_stm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        WB,
        DONE
    } state_t;

    localparam logic [3:0] REG_PC     = 4'd15;
    localparam int         WORD_BYTES = 4;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + {4'd0, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/ldm_stm_seq_if.sv
// Data-memory request/acknowledge port used by the sequencer.
// The sequencer is the master; the memory system is the slave.
interface ldm_stm_seq_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/ldm_stm_seq_lsb_prio_enc.sv
// 16-bit lowest-set-bit priority encoder.
// idx is 0 when no bit is set; valid flags a non-empty vector.
module lsb_prio_enc (
    input  logic [15:0] vec,
    output logic [3:0]  idx,
    output logic        valid
);

    always_comb begin
        idx   = '0;
        valid = |vec;
        // Scan downwards so the lowest set bit wins.
        for (int i = 15; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 4'(i);
            end
        end
    end

endmodule

// File: rtl/ldm_stm_seq.sv
// Load/store-multiple sequencer: walks a register list, one memory word per
// listed register, then optionally writes the updated base back to rn.
module ldm_stm_seq
    import ldm_stm_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          is_load,
    input  logic [15:0]   rlist,
    input  logic [3:0]    rn,
    input  logic [AW-1:0] base,
    input  logic          up,
    input  logic          pre,
    input  logic          wback,
    output logic          busy,
    output logic          done,
    output logic [3:0]    ra,
    input  logic [DW-1:0] rd,
    output logic          we,
    output logic [3:0]    wa,
    output logic [DW-1:0] wd,
    output logic          pc_we,
    output logic [DW-1:0] pc_wd,
    ldm_stm_seq_if.master mem
);

    state_t        state_reg,   state_next;
    logic [15:0]   pending_reg, pending_next;
    logic [AW-1:0] addr_reg,    addr_next;
    logic [AW-1:0] final_reg,   final_next;
    logic [3:0]    rn_reg,      rn_next;
    logic          load_reg,    load_next;
    logic          do_wb_reg,   do_wb_next;

    logic [3:0]    cur;
    logic          cur_valid;
    logic [4:0]    n_regs;
    logic [AW-1:0] span;
    logic [AW-1:0] word;

    lsb_prio_enc u_enc (
        .vec   (pending_reg),
        .idx   (cur),
        .valid (cur_valid)
    );

    assign n_regs = popcount16(rlist);
    assign word   = AW'(WORD_BYTES);
    assign span   = AW'(n_regs) * word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            pending_reg <= '0;
            addr_reg    <= '0;
            final_reg   <= '0;
            rn_reg      <= '0;
            load_reg    <= 1'b0;
            do_wb_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
            addr_reg    <= addr_next;
            final_reg   <= final_next;
            rn_reg      <= rn_next;
            load_reg    <= load_next;
            do_wb_reg   <= do_wb_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pending_next = pending_reg;
        addr_next    = addr_reg;
        final_next   = final_reg;
        rn_next      = rn_reg;
        load_next    = load_reg;
        do_wb_next   = do_wb_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    pending_next = rlist;
                    rn_next      = rn;
                    load_next    = is_load;
                    // A load that overwrites the base register keeps the loaded value.
                    do_wb_next   = wback && !(is_load && rlist[rn]);
                    final_next   = up ? base + span : base - span;
                    if (up) begin
                        addr_next = pre ? base + word : base;
                    end else begin
                        addr_next = pre ? base - span : base - span + word;
                    end
                    state_next = (rlist != 16'd0) ? XFER : DONE;
                end
            end
            XFER: begin
                if (mem.mem_ack) begin
                    pending_next = pending_reg & ~(16'd1 << cur);
                    addr_next    = addr_reg + word;
                    if (pending_next == 16'd0) begin
                        state_next = do_wb_reg ? WB : DONE;
                    end
                end
            end
            WB:      state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy          = 1'b0;
        done          = 1'b0;
        ra            = '0;
        we            = 1'b0;
        wa            = '0;
        wd            = '0;
        pc_we         = 1'b0;
        pc_wd         = '0;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;

        case (state_reg)
            XFER: begin
                busy          = 1'b1;
                mem.mem_req   = cur_valid;
                mem.mem_we    = !load_reg;
                mem.mem_addr  = addr_reg;
                ra            = cur;
                mem.mem_wdata = rd;
                if (mem.mem_ack && load_reg) begin
                    if (cur == REG_PC) begin
                        pc_we = 1'b1;
                        pc_wd = mem.mem_rdata;
                    end else begin
                        we = 1'b1;
                        wa = cur;
                        wd = mem.mem_rdata;
                    end
                end
            end
            WB: begin
                busy = 1'b1;
                // Writing the PC as a base register is not supported.
                we   = (rn_reg != REG_PC);
                wa   = rn_reg;
                wd   = DW'(final_reg);
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Self-checking bench for ldm_stm_seq: directed cases plus random sequences
// compared against a transfer-list model derived from the addressing rules.
module tb_ldm_stm_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        is_load;
    logic [15:0] rlist;
    logic [3:0]  rn;
    logic [31:0] base;
    logic        up;
    logic        pre;
    logic        wback;
    logic        busy;
    logic        done;
    logic [3:0]  ra;
    logic [31:0] rd;
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic        pc_we;
    logic [31:0] pc_wd;

    logic [31:0] regs [16];
    int checks   = 0;
    int failures = 0;

    ldm_stm_seq_if #(.AW(32), .DW(32)) mem_if ();

    ldm_stm_seq #(.AW(32), .DW(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .is_load (is_load),
        .rlist   (rlist),
        .rn      (rn),
        .base    (base),
        .up      (up),
        .pre     (pre),
        .wback   (wback),
        .busy    (busy),
        .done    (done),
        .ra      (ra),
        .rd      (rd),
        .we      (we),
        .wa      (wa),
        .wd      (wd),
        .pc_we   (pc_we),
        .pc_wd   (pc_wd),
        .mem     (mem_if.master)
    );

    always #5 clk = ~clk;

    assign rd = regs[ra];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".busy"},  32'(busy),            32'd0);
        check({tag, ".done"},  32'(done),            32'd0);
        check({tag, ".req"},   32'(mem_if.mem_req),  32'd0);
        check({tag, ".mwe"},   32'(mem_if.mem_we),   32'd0);
        check({tag, ".addr"},  mem_if.mem_addr,      32'd0);
        check({tag, ".wdata"}, mem_if.mem_wdata,     32'd0);
        check({tag, ".we"},    32'(we),              32'd0);
        check({tag, ".pc_we"}, 32'(pc_we),           32'd0);
        check({tag, ".ra"},    32'(ra),              32'd0);
        check({tag, ".wa"},    32'(wa),              32'd0);
        check({tag, ".wd"},    wd,                   32'd0);
        check({tag, ".pc_wd"}, pc_wd,                32'd0);
    endtask

    // Model: the listed registers in ascending order occupy a contiguous word
    // block whose lowest address follows from base, direction and pre/post.
    task automatic run_seq(input logic ld, input logic [15:0] rl, input logic [3:0] rnn,
                           input logic [31:0] b, input logic u, input logic p,
                           input logic wbk, input int maxd, input logic poke);
        int          regq[$];
        int          n;
        int          r;
        int          d;
        logic [31:0] fin;
        logic [31:0] lowest;
        logic [31:0] a;
        logic [31:0] dat;
        logic        wb_exp;

        n = 0;
        for (int i = 0; i < 16; i++) begin
            if (rl[i]) begin
                regq.push_back(i);
                n++;
            end
        end
        fin    = u ? b + 32'(4 * n) : b - 32'(4 * n);
        lowest = u ? (p ? b + 32'd4 : b) : (p ? fin : fin + 32'd4);
        wb_exp = wbk && (n != 0) && !(ld && rl[rnn]);

        @(negedge clk);
        start = 1'b1; is_load = ld; rlist = rl; rn = rnn; base = b;
        up = u; pre = p; wback = wbk;
        @(posedge clk);
        #1;
        start = 1'b0; rlist = 16'($urandom); base = $urandom; rn = 4'($urandom);

        for (int k = 0; k < n; k++) begin
            r = regq[k];
            a = lowest + 32'(4 * k);
            d = $urandom_range(0, maxd);
            for (int w = 0; w <= d; w++) begin
                @(negedge clk);
                if (poke && k == 0 && w == 0) begin
                    start = 1'b1; rlist = 16'($urandom); is_load = ~ld;
                end
                dat = $urandom;
                mem_if.mem_ack   = (w == d);
                mem_if.mem_rdata = dat;
                #1;
                check("xfer.busy", 32'(busy),           32'd1);
                check("xfer.req",  32'(mem_if.mem_req), 32'd1);
                check("xfer.mwe",  32'(mem_if.mem_we),  32'(!ld));
                check("xfer.addr", mem_if.mem_addr,     a);
                check("xfer.ra",   32'(ra),             32'(r));
                if (!ld) check("xfer.wdata", mem_if.mem_wdata, regs[r]);
                if (w == d && ld && r != 15) begin
                    check("ld.we",    32'(we),    32'd1);
                    check("ld.wa",    32'(wa),    32'(r));
                    check("ld.wd",    wd,         dat);
                    check("ld.pc_we", 32'(pc_we), 32'd0);
                end else if (w == d && ld) begin
                    check("ldpc.pc_we", 32'(pc_we), 32'd1);
                    check("ldpc.pc_wd", pc_wd,      dat);
                    check("ldpc.we",    32'(we),    32'd0);
                end else begin
                    check("xfer.we",    32'(we),    32'd0);
                    check("xfer.pc_we", 32'(pc_we), 32'd0);
                end
                @(posedge clk);
                #1;
                start = 1'b0;
                if (w == d && ld && r != 15) regs[r] = dat;
            end
        end
        mem_if.mem_ack = 1'b0;

        if (wb_exp) begin
            @(negedge clk);
            #1;
            check("wb.busy", 32'(busy),           32'd1);
            check("wb.req",  32'(mem_if.mem_req), 32'd0);
            check("wb.we",   32'(we),             32'd1);
            check("wb.wa",   32'(wa),             32'(rnn));
            check("wb.wd",   wd,                  fin);
            check("wb.done", 32'(done),           32'd0);
            @(posedge clk);
            regs[rnn] = fin;
        end

        @(negedge clk);
        #1;
        check("done.done", 32'(done),           32'd1);
        check("done.busy", 32'(busy),           32'd1);
        check("done.req",  32'(mem_if.mem_req), 32'd0);
        check("done.we",   32'(we),             32'd0);
        @(negedge clk);
        #1;
        check("idle.done", 32'(done), 32'd0);
        check("idle.busy", 32'(busy), 32'd0);
        $display("seq ld=%0d rlist=%h rn=%0d base=%h up=%0d pre=%0d wb=%0d lowest=%h final=%h wbcyc=%0d",
                 ld, rl, rnn, b, u, p, wbk, lowest, fin, wb_exp);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; is_load = 1'b0; rlist = '0; rn = '0;
        base = '0; up = 1'b0; pre = 1'b0; wback = 1'b0;
        mem_if.mem_ack = 1'b0; mem_if.mem_rdata = '0;
        for (int i = 0; i < 16; i++) regs[i] = $urandom;

        repeat (2) @(negedge clk);
        check_quiet("reset");
        rst_n = 1'b1;

        // STM IA with writeback, single-cycle acks
        regs[0] = 32'hAAAA_0000; regs[1] = 32'hBBBB_1111; regs[2] = 32'hCCCC_2222;
        run_seq(1'b0, 16'h0007, 4'd3, 32'h100, 1'b1, 1'b0, 1'b1, 0, 1'b0);
        // LDM DB including PC, delayed acks
        run_seq(1'b1, 16'h8003, 4'd4, 32'h200, 1'b0, 1'b1, 1'b0, 2, 1'b0);
        // LDM IA, base in list suppresses writeback
        run_seq(1'b1, 16'h0006, 4'd1, 32'h300, 1'b1, 1'b0, 1'b1, 1, 1'b0);
        // Empty list
        run_seq(1'b0, 16'h0000, 4'd2, 32'h400, 1'b1, 1'b0, 1'b1, 0, 1'b0);
        // start while busy is ignored
        run_seq(1'b0, 16'h0130, 4'd6, 32'h500, 1'b1, 1'b1, 1'b1, 1, 1'b1);
        // DA wrap below zero
        run_seq(1'b0, 16'h000F, 4'd5, 32'h0000_0004, 1'b0, 1'b0, 1'b1, 0, 1'b0);

        // Reset in the middle of a transfer
        @(negedge clk);
        start = 1'b1; is_load = 1'b0; rlist = 16'hFFFF; rn = 4'd0; base = 32'h1000;
        up = 1'b1; pre = 1'b0; wback = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("prerst.req", 32'(mem_if.mem_req), 32'd1);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_quiet("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        run_seq(1'b1, 16'h0041, 4'd7, 32'h2000, 1'b1, 1'b1, 1'b1, 1, 1'b0);

        for (int t = 0; t < 30; t++) begin
            run_seq(1'($urandom), 16'($urandom & $urandom), 4'($urandom_range(0, 14)),
                    $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 2, 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
